// File: rtl/router_sync_n.sv
// rtl/router_sync_n.sv - address latch, write steering, valid/full muxing and read-timeout soft resets for a 1xN router
module router_sync_n #(
  parameter int NUM_CH  = 3,
  parameter int ADDR_W  = 2,
  parameter int TIMEOUT = 30,
  parameter int TMR_W   = 5,
  parameter int CNT_W   = 8
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              detect_add,
  input  logic              write_enb_reg,
  input  logic [ADDR_W-1:0] data_in,
  input  logic [NUM_CH-1:0] read_enb,
  input  logic [NUM_CH-1:0] empty,
  input  logic [NUM_CH-1:0] full,
  output logic              fifo_full,
  output logic [NUM_CH-1:0] write_enb,
  output logic [NUM_CH-1:0] vld_out,
  output logic [NUM_CH-1:0] soft_reset,
  output logic              addr_err,
  output logic [CNT_W-1:0]  sr_count
);

  logic [ADDR_W-1:0] fifo_addr_q, fifo_addr_d;
  logic              addr_err_q, addr_err_d;
  logic [TMR_W-1:0]  timer_q [NUM_CH];
  logic [TMR_W-1:0]  timer_d [NUM_CH];
  logic [NUM_CH-1:0] soft_reset_q, soft_reset_d;
  logic [CNT_W-1:0]  sr_count_q, sr_count_d;
  logic [NUM_CH-1:0] addr_hit;
  logic [4:0]        pulse_cnt;
  logic [CNT_W+4:0]  cnt_sum;

  // Destination address and its validity are captured only on a header byte.
  always_comb begin
    fifo_addr_d = fifo_addr_q;
    addr_err_d  = addr_err_q;
    if (detect_add) begin
      fifo_addr_d = data_in;
      addr_err_d  = (32'(data_in) >= NUM_CH);
    end
  end

  // Decode the latched address; an out-of-range address selects nothing.
  always_comb begin
    addr_hit = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      addr_hit[i] = (32'(fifo_addr_q) == i);
    end
  end

  // Write steering and full muxing; gated by resetn so both read 0 while in reset.
  always_comb begin
    write_enb = '0;
    fifo_full = 1'b0;
    if (resetn && !addr_err_q) begin
      if (write_enb_reg) begin
        write_enb = addr_hit;
      end
      fifo_full = |(full & addr_hit);
    end
  end

  // Per-channel idle-valid timers; a pulse is issued when a channel sits unread for TIMEOUT edges.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      timer_d[i]      = timer_q[i];
      soft_reset_d[i] = 1'b0;
      if (empty[i] || read_enb[i]) begin
        timer_d[i] = '0;
      end else if (timer_q[i] == TMR_W'(TIMEOUT - 1)) begin
        soft_reset_d[i] = 1'b1;
        timer_d[i]      = '0;
      end else begin
        timer_d[i] = timer_q[i] + 1'b1;
      end
    end
  end

  // Add this edge's pulses to the event counter, saturating instead of wrapping.
  always_comb begin
    pulse_cnt = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      pulse_cnt = pulse_cnt + {4'b0, soft_reset_d[i]};
    end
    cnt_sum = {5'b0, sr_count_q} + {{CNT_W{1'b0}}, pulse_cnt};
    if (cnt_sum > {5'b0, {CNT_W{1'b1}}}) begin
      sr_count_d = {CNT_W{1'b1}};
    end else begin
      sr_count_d = cnt_sum[CNT_W-1:0];
    end
  end

  // State registers, cleared asynchronously by resetn.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      fifo_addr_q  <= '0;
      addr_err_q   <= 1'b0;
      soft_reset_q <= '0;
      sr_count_q   <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        timer_q[i] <= '0;
      end
    end else begin
      fifo_addr_q  <= fifo_addr_d;
      addr_err_q   <= addr_err_d;
      soft_reset_q <= soft_reset_d;
      sr_count_q   <= sr_count_d;
      for (int i = 0; i < NUM_CH; i++) begin
        timer_q[i] <= timer_d[i];
      end
    end
  end

  assign vld_out    = ~empty;
  assign soft_reset = soft_reset_q;
  assign addr_err   = addr_err_q;
  assign sr_count   = sr_count_q;

endmodule

// File: tb/tb_router_sync_n.sv
// tb/tb_router_sync_n.sv - directed self-checking bench for router_sync_n
module tb_router_sync_n;

  logic       clock;
  logic       resetn;
  logic       detect_add, write_enb_reg;
  logic [1:0] data_in;
  logic [2:0] read_enb, empty, full;

  logic       a_fifo_full, a_addr_err;
  logic [2:0] a_write_enb, a_vld_out, a_soft_reset;
  logic [7:0] a_sr_count;

  logic       b_fifo_full, b_addr_err;
  logic [2:0] b_write_enb, b_vld_out, b_soft_reset;
  logic [1:0] b_sr_count;

  logic       c_detect_add, c_write_enb_reg;
  logic [2:0] c_data_in;
  logic [7:0] c_read_enb, c_empty, c_full;
  logic       c_fifo_full, c_addr_err;
  logic [7:0] c_write_enb, c_vld_out, c_soft_reset;
  logic [7:0] c_sr_count;

  int checks = 0;
  int errors = 0;

  router_sync_n u_a (
    .clock(clock), .resetn(resetn), .detect_add(detect_add), .write_enb_reg(write_enb_reg),
    .data_in(data_in), .read_enb(read_enb), .empty(empty), .full(full),
    .fifo_full(a_fifo_full), .write_enb(a_write_enb), .vld_out(a_vld_out),
    .soft_reset(a_soft_reset), .addr_err(a_addr_err), .sr_count(a_sr_count)
  );

  router_sync_n #(.CNT_W(2)) u_b (
    .clock(clock), .resetn(resetn), .detect_add(detect_add), .write_enb_reg(write_enb_reg),
    .data_in(data_in), .read_enb(read_enb), .empty(empty), .full(full),
    .fifo_full(b_fifo_full), .write_enb(b_write_enb), .vld_out(b_vld_out),
    .soft_reset(b_soft_reset), .addr_err(b_addr_err), .sr_count(b_sr_count)
  );

  router_sync_n #(.NUM_CH(8), .ADDR_W(3), .TIMEOUT(5), .TMR_W(3), .CNT_W(8)) u_c (
    .clock(clock), .resetn(resetn), .detect_add(c_detect_add), .write_enb_reg(c_write_enb_reg),
    .data_in(c_data_in), .read_enb(c_read_enb), .empty(c_empty), .full(c_full),
    .fifo_full(c_fifo_full), .write_enb(c_write_enb), .vld_out(c_vld_out),
    .soft_reset(c_soft_reset), .addr_err(c_addr_err), .sr_count(c_sr_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    resetn = 1'b0; detect_add = 1'b0; write_enb_reg = 1'b0; data_in = 2'd0;
    read_enb = 3'b000; empty = 3'b111; full = 3'b000;
    c_detect_add = 1'b0; c_write_enb_reg = 1'b0; c_data_in = 3'd0;
    c_read_enb = 8'h00; c_empty = 8'hFF; c_full = 8'h00;

    // Reset values
    tick;
    chk("rst_write_enb", a_write_enb, 3'b000);
    chk("rst_fifo_full", a_fifo_full, 1'b0);
    chk("rst_soft_reset", a_soft_reset, 3'b000);
    chk("rst_addr_err", a_addr_err, 1'b0);
    chk("rst_sr_count", a_sr_count, 8'd0);
    empty = 3'b010;
    #1;
    chk("rst_vld_out", a_vld_out, 3'b101);
    empty = 3'b111;
    write_enb_reg = 1'b1;
    #1;
    chk("rst_write_enb_req", a_write_enb, 3'b000);
    write_enb_reg = 1'b0;
    resetn = 1'b1;

    // Address steering
    detect_add = 1'b1; data_in = 2'd2;
    tick;
    detect_add = 1'b0; write_enb_reg = 1'b1; full = 3'b100;
    #1;
    chk("steer2_write_enb", a_write_enb, 3'b100);
    chk("steer2_fifo_full", a_fifo_full, 1'b1);
    full = 3'b011;
    #1;
    chk("steer2_fifo_full_comb", a_fifo_full, 1'b0);
    detect_add = 1'b1; data_in = 2'd0;
    #1;
    chk("simul_pre_edge", a_write_enb, 3'b100);
    tick;
    detect_add = 1'b0; full = 3'b001;
    #1;
    chk("steer0_write_enb", a_write_enb, 3'b001);
    chk("steer0_fifo_full", a_fifo_full, 1'b1);
    detect_add = 1'b1; data_in = 2'd1;
    tick;
    detect_add = 1'b0;
    #1;
    chk("steer1_write_enb", a_write_enb, 3'b010);
    chk("steer1_fifo_full", a_fifo_full, 1'b0);
    write_enb_reg = 1'b0;
    #1;
    chk("steer_idle", a_write_enb, 3'b000);

    // Invalid address
    detect_add = 1'b1; data_in = 2'd3;
    tick;
    detect_add = 1'b0; write_enb_reg = 1'b1; full = 3'b111;
    #1;
    chk("inv_addr_err", a_addr_err, 1'b1);
    chk("inv_write_enb", a_write_enb, 3'b000);
    chk("inv_fifo_full", a_fifo_full, 1'b0);
    detect_add = 1'b1; data_in = 2'd1;
    tick;
    detect_add = 1'b0;
    #1;
    chk("inv_clear_addr_err", a_addr_err, 1'b0);
    chk("inv_clear_write_enb", a_write_enb, 3'b010);
    write_enb_reg = 1'b0; full = 3'b000;

    // Timeout on channel 0: pulses after edges 30 and 60
    empty = 3'b110;
    for (int k = 1; k <= 60; k++) begin
      tick;
      chk($sformatf("to_sr_%0d", k), a_soft_reset, (k == 30 || k == 60) ? 3'b001 : 3'b000);
      if (k == 30) chk("to_sr_count_1", a_sr_count, 8'd1);
    end
    chk("to_sr_count_2", a_sr_count, 8'd2);
    chk("to_b_sr_count_2", b_sr_count, 2'd2);

    // Read abort at edge 29
    for (int k = 1; k <= 40; k++) begin
      read_enb = (k == 29) ? 3'b001 : 3'b000;
      tick;
      chk($sformatf("abort_sr_%0d", k), a_soft_reset, 3'b000);
    end
    read_enb = 3'b000;
    empty = 3'b111;
    tick;

    // Simultaneous timeouts and saturation of the CNT_W=2 instance
    empty = 3'b000;
    for (int k = 1; k <= 61; k++) begin
      tick;
      chk($sformatf("sim_sr_%0d", k), a_soft_reset, (k == 30 || k == 60) ? 3'b111 : 3'b000);
      if (k == 30) begin
        chk("sim_a_count_5", a_sr_count, 8'd5);
        chk("sim_b_count_sat", b_sr_count, 2'd3);
      end
    end
    chk("sim_a_count_8", a_sr_count, 8'd8);
    chk("sim_b_count_nowrap", b_sr_count, 2'd3);
    empty = 3'b111;
    tick;

    // Reset mid-count with timer[1] at 17
    empty = 3'b101; write_enb_reg = 1'b1; full = 3'b010;
    for (int k = 1; k <= 17; k++) tick;
    chk("mid_pre_write_enb", a_write_enb, 3'b010);
    chk("mid_pre_fifo_full", a_fifo_full, 1'b1);
    #2;
    resetn = 1'b0;
    #1;
    chk("mid_write_enb", a_write_enb, 3'b000);
    chk("mid_fifo_full", a_fifo_full, 1'b0);
    chk("mid_soft_reset", a_soft_reset, 3'b000);
    chk("mid_addr_err", a_addr_err, 1'b0);
    chk("mid_sr_count", a_sr_count, 8'd0);
    chk("mid_b_sr_count", b_sr_count, 2'd0);
    chk("mid_vld_out", a_vld_out, 3'b010);
    #1;
    resetn = 1'b1;
    for (int k = 1; k <= 31; k++) begin
      tick;
      chk($sformatf("mid_sr_%0d", k), a_soft_reset, (k == 30) ? 3'b010 : 3'b000);
    end
    chk("mid_post_count", a_sr_count, 8'd1);
    empty = 3'b111; write_enb_reg = 1'b0; full = 3'b000;

    // Parameter sweep instance: 8 channels, TIMEOUT=5
    for (int a = 0; a < 8; a++) begin
      c_detect_add = 1'b1; c_data_in = 3'(a);
      tick;
      c_detect_add = 1'b0; c_write_enb_reg = 1'b1; c_full = 8'(32'd1 << a);
      #1;
      chk($sformatf("sweep_we_%0d", a), c_write_enb, 32'd1 << a);
      chk($sformatf("sweep_ff_%0d", a), c_fifo_full, 1'b1);
      c_write_enb_reg = 1'b0; c_full = 8'h00;
    end
    chk("sweep_addr_err", c_addr_err, 1'b0);
    c_empty = 8'hFE;
    for (int k = 1; k <= 6; k++) begin
      tick;
      chk($sformatf("sweep_sr_%0d", k), c_soft_reset, (k == 5) ? 8'h01 : 8'h00);
    end
    chk("sweep_sr_count", c_sr_count, 8'd1);
    c_empty = 8'hFF;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
